alu_seq_core: RTL and testbench
===============================

# alu_seq_core

Parametrised, multi-cycle successor to the team's single-cycle 8-bit ALU top (`tt_um_ALUUAriaMitra`). It adds a valid/ready handshake, an accumulator feedback path, iterative shifts and a shift-add multiplier. It sits behind the TinyTapeout pin wrapper, which maps `ui_in`/`uio_in` to operands and `uo_out` to results. It can also be instantiated at wider `WIDTH` in later tiles.

## Interface
- `WIDTH`, 8: operand/result width; must be ≥4 and a power of two.
- `SHW`, $clog2(WIDTH): shift-amount width (derived; do not override).
- `clk`  in  1: single clock; all state on rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `ena`  in  1: design enable; low freezes all state, forces `in_ready`=0, holds `out_valid`.
- `in_valid`  in  1: request valid.
- `in_ready`  out  1: high only in IDLE with `ena`=1.
- `op`  in  3: opcode (see Operation).
- `a`, `b`  in  WIDTH: operands.
- `use_acc`  in  1: replace `a` with accumulator.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer accepts result.
- `result`  out  WIDTH: low result.
- `hi`  out  WIDTH: MUL upper half; 0 for other ops.
- `flags`  out  4: {Z,N,C,V}.

## Operation
- Opcodes: 0 ADD, 1 SUB (a−b), 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 MUL (unsigned, 2·WIDTH product).
- Accept = `in_valid & in_ready`. Operands, op and `use_acc` are latched on accept and never re-sampled.
- FSM IDLE→EXEC→DONE→IDLE.
  - IDLE: accept → EXEC.
  - EXEC: counts down the op-specific cycle count, then → DONE.
  - DONE: holds `out_valid`=1 with stable outputs until `out_ready`, then → IDLE.
- ALU ops 0–4: EXEC lasts 1 cycle.
- Shifts: s = `b[SHW-1:0]`; one bit per cycle; EXEC lasts max(s,1) cycles; s=0 returns `a` unchanged.
- MUL: shift-add, one multiplier bit per cycle; EXEC lasts WIDTH cycles.
- Accumulator: loaded with `result` on each output handshake (`out_valid & out_ready`). Reset value 0.
- Flags (computed at end of EXEC):
  - Z = (`result`==0 && `hi`==0).
  - N = `result[WIDTH-1]`.
  - C: carry-out for ADD; borrow (a<b unsigned) for SUB; last bit shifted out for shifts (0 if s=0); (`hi`≠0) for MUL; 0 for logic ops.
  - V: signed overflow for ADD/SUB; 0 otherwise.
- Widths: ADD/SUB wrap modulo 2^WIDTH. MUL result=low, `hi`=high half.
- `in_valid` while busy: ignored (no queue). The requester holds it until accepted.
- Reset has priority over `ena` and aborts any op: no `out_valid` is produced for it.

## Timing
- Reset values: `in_ready`=1 (when `ena`), `out_valid`=0, `result`=0, `hi`=0, `flags`=0, acc=0, FSM=IDLE.
- Latency, accept edge to `out_valid` high: ALU ops 2 cycles; shifts max(s,1)+1; MUL WIDTH+1.
- Back-to-back throughput: the next accept is possible in the cycle after the output handshake (IDLE re-entered). Best case is one op per 3 cycles.
- Outputs are registered, with no combinational path from inputs to outputs. `in_ready` is decoded from state and `ena` only.
- `ena` deassert mid-EXEC: counter and datapath hold; on reassert the op resumes with identical final result.
- `use_acc` on the accept directly after a handshake sees the just-loaded accumulator value.

## Structure
- Package `alu_seq_pkg` holds:
  - opcode enum (`OP_ADD`..`OP_MUL`);
  - FSM state enum;
  - flag bit indices (`FLG_Z`=3, `FLG_N`=2, `FLG_C`=1, `FLG_V`=0).
- Sub-module `alu_seq_comb`: combinational ops 0–4 plus flag generation, parametrised by WIDTH.
- Shifter, multiplier, counter and FSM live in `alu_seq_core`.
- The TT wrapper instantiates it with WIDTH=8.

## Test plan
- WIDTH=8, ADD 0x7F+0x01 → `result`=0x80, `flags`=N,V (0b0101), `out_valid` 2 cycles after accept.
- SUB 0x03−0x05 → `result`=0xFE, N=1, C=1, V=0; a second SUB with `use_acc`=1 and `b`=0xFE → `result`=0x00, Z=1.
- SHL `a`=0x81, `b`=3 → `result`=0x08, C=0, latency 4. SHR `a`=0x81, `b`=1 → `result`=0x40, C=1. Shift with `b`=0 → `result`=`a`, latency 2.
- MUL 0xFF×0xFF → `hi`=0xFE, `result`=0x01, C=1, latency 9. Holding `out_ready`=0 for 5 cycles keeps outputs stable and `in_ready`=0.
- Toggle `ena` low for 3 cycles mid-MUL 0x0C×0x0D → result still 0x009C, latency extended by exactly 3.
- Assert `rst_n`=0 for one cycle mid-MUL → next cycle all outputs at reset values, no `out_valid`; a fresh ADD then completes normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and flag bit positions.
package alu_seq_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_SHL = 3'd5,
      OP_SHR = 3'd6,
      OP_MUL = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int FLG_Z = 3;
   localparam int FLG_N = 2;
   localparam int FLG_C = 1;
   localparam int FLG_V = 0;

endpackage

// File: rtl/alu_seq_comb.sv
// Single-cycle arithmetic/logic ops (ADD..XOR) with {Z,N,C,V} flag generation.
module alu_seq_comb
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  op_e              op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] res,
   output logic [3:0]       flags
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] diff;

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      sum   = {1'b0, a} + {1'b0, b};
      diff  = {1'b0, a} - {1'b0, b};
      res   = '0;
      flags = '0;
      case (op)
         OP_ADD: begin
            res          = sum[WIDTH-1:0];
            flags[FLG_C] = sum[WIDTH];
            flags[FLG_V] = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            res          = diff[WIDTH-1:0];
            flags[FLG_C] = diff[WIDTH];
            flags[FLG_V] = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         OP_XOR:  res = a ^ b;
         default: res = '0;
      endcase
      flags[FLG_Z] = (res == '0);
      flags[FLG_N] = res[WIDTH-1];
   end

endmodule

// File: rtl/alu_seq_core.sv
// Multi-cycle ALU with valid/ready handshake, accumulator feedback,
// bit-serial shifter and shift-add multiplier.
module alu_seq_core
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             use_acc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] hi,
   output logic [3:0]       flags
);

   localparam int CW = SHW + 1;

   state_e             state_q, state_d;
   op_e                op_q, op_d;
   logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d, acc_q, acc_d;
   logic [WIDTH-1:0]   result_q, result_d, hi_q, hi_d;
   logic [3:0]         flags_q, flags_d;
   logic [2*WIDTH-1:0] wk_q, wk_d;
   logic               carry_q, carry_d;
   logic [CW-1:0]      cnt_q, cnt_d;

   logic               accept, out_hs, exec_en, last_step;
   logic [WIDTH-1:0]   comb_res;
   logic [3:0]         comb_flags;
   logic [WIDTH:0]     mul_sum;

   function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] lo,
                                             input logic [WIDTH-1:0] up,
                                             input logic             c);
      logic [3:0] f;
      f        = '0;
      f[FLG_Z] = (lo == '0) && (up == '0);
      f[FLG_N] = lo[WIDTH-1];
      f[FLG_C] = c;
      return f;
   endfunction

   alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
      .op    (op_q),
      .a     (opa_q),
      .b     (opb_q),
      .res   (comb_res),
      .flags (comb_flags)
   );

   assign accept    = in_valid & in_ready;
   assign out_hs    = ena & out_valid & out_ready;
   assign exec_en   = ena & (state_q == ST_EXEC);
   assign last_step = (cnt_q <= CW'(1));

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (ena) begin
         case (state_q)
            ST_IDLE: if (in_valid)  state_d = ST_EXEC;
            ST_EXEC: if (last_step) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready  = ena && (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
   end

   always_comb begin
      op_d     = op_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      acc_d    = acc_q;
      result_d = result_q;
      hi_d     = hi_q;
      flags_d  = flags_q;
      wk_d     = wk_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      mul_sum  = '0;

      if (accept) begin
         op_d    = op_e'(op);
         opa_d   = use_acc ? acc_q : a;
         opb_d   = b;
         carry_d = 1'b0;
         case (op_e'(op))
            OP_SHL, OP_SHR: begin
               cnt_d = {1'b0, b[SHW-1:0]};
               wk_d  = {{WIDTH{1'b0}}, opa_d};
            end
            OP_MUL: begin
               cnt_d = CW'(WIDTH);
               wk_d  = {{WIDTH{1'b0}}, b};
            end
            default: begin
               cnt_d = CW'(1);
               wk_d  = '0;
            end
         endcase
      end

      if (exec_en) begin
         if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
         case (op_q)
            OP_SHL: if (cnt_q != '0) begin
               carry_d           = wk_q[WIDTH-1];
               wk_d[WIDTH-1:0]   = {wk_q[WIDTH-2:0], 1'b0};
            end
            OP_SHR: if (cnt_q != '0) begin
               carry_d           = wk_q[0];
               wk_d[WIDTH-1:0]   = {1'b0, wk_q[WIDTH-1:1]};
            end
            OP_MUL: begin
               // Upper half accumulates the multiplicand; the multiplier drains out of the low half.
               mul_sum = {1'b0, wk_q[2*WIDTH-1:WIDTH]} + (wk_q[0] ? {1'b0, opa_q} : '0);
               wk_d    = {mul_sum, wk_q[WIDTH-1:1]};
            end
            default: ;
         endcase
         if (last_step) begin
            case (op_q)
               OP_SHL, OP_SHR: begin
                  result_d = wk_d[WIDTH-1:0];
                  hi_d     = '0;
                  flags_d  = pack_flags(result_d, hi_d, carry_d);
               end
               OP_MUL: begin
                  result_d = wk_d[WIDTH-1:0];
                  hi_d     = wk_d[2*WIDTH-1:WIDTH];
                  flags_d  = pack_flags(result_d, hi_d, hi_d != '0);
               end
               default: begin
                  result_d = comb_res;
                  hi_d     = '0;
                  flags_d  = comb_flags;
               end
            endcase
         end
      end

      if (out_hs) acc_d = result_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q     <= OP_ADD;
         opa_q    <= '0;
         opb_q    <= '0;
         acc_q    <= '0;
         result_q <= '0;
         hi_q     <= '0;
         flags_q  <= '0;
         wk_q     <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         op_q     <= op_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         hi_q     <= hi_d;
         flags_q  <= flags_d;
         wk_q     <= wk_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
      end
   end

   assign result = result_q;
   assign hi     = hi_q;
   assign flags  = flags_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed-vector bench for alu_seq_core at WIDTH=8 with hand-computed expectations.
module tb_alu_seq_core;
   import alu_seq_pkg::*;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n, ena, in_valid, in_ready, use_acc, out_valid, out_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] a, b, result, hi;
   logic [3:0]       flags;

   int n_vec  = 0;
   int n_miss = 0;

   alu_seq_core #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .use_acc   (use_acc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .hi        (hi),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] o, input logic [7:0] va, input logic [7:0] vb,
                        input logic ua);
      int guard;
      guard = 0;
      while (!in_ready && guard < 20) begin
         step();
         guard++;
      end
      check("in_ready_before_issue", 32'(in_ready), 32'(1));
      op = o; a = va; b = vb; use_acc = ua; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      a = 8'hA5; b = 8'h5A; use_acc = 1'b0; op = OP_XOR;
   endtask

   task automatic wait_valid(inout int lat);
      while (!out_valid && lat < 40) begin
         step();
         lat++;
      end
      check("out_valid_seen", 32'(out_valid), 32'(1));
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("out_valid_after_hs", 32'(out_valid), 32'(0));
      check("in_ready_after_hs", 32'(in_ready), 32'(1));
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] va,
                         input logic [7:0] vb, input logic ua, input logic [7:0] er,
                         input logic [7:0] eh, input logic [3:0] ef, input int elat);
      int lat;
      issue(o, va, vb, ua);
      lat = 1;
      wait_valid(lat);
      check({tag, "_lat"},    32'(lat),    32'(elat));
      check({tag, "_result"}, 32'(result), 32'(er));
      check({tag, "_hi"},     32'(hi),     32'(eh));
      check({tag, "_flags"},  32'(flags),  32'(ef));
      handshake();
   endtask

   initial begin
      int  lat;
      logic seen;

      rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      op = OP_ADD; a = '0; b = '0; use_acc = 1'b0;
      step(); step();
      check("rst_in_ready",  32'(in_ready),  32'(1));
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_result",    32'(result),    32'(0));
      check("rst_hi",        32'(hi),        32'(0));
      check("rst_flags",     32'(flags),     32'(0));
      rst_n = 1'b1;
      step();

      run_op("add_ovf",  OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 8'h00, 4'b0101, 2);
      run_op("sub_brw",  OP_SUB, 8'h03, 8'h05, 1'b0, 8'hFE, 8'h00, 4'b0110, 2);
      run_op("sub_acc",  OP_SUB, 8'h77, 8'hFE, 1'b1, 8'h00, 8'h00, 4'b1000, 2);
      run_op("shl3",     OP_SHL, 8'h81, 8'h03, 1'b0, 8'h08, 8'h00, 4'b0000, 4);
      run_op("shr1",     OP_SHR, 8'h81, 8'h01, 1'b0, 8'h40, 8'h00, 4'b0010, 2);
      run_op("shl0",     OP_SHL, 8'h5A, 8'h00, 1'b0, 8'h5A, 8'h00, 4'b0000, 2);
      run_op("shr4",     OP_SHR, 8'hF0, 8'h0C, 1'b0, 8'h0F, 8'h00, 4'b0000, 5);
      run_op("and",      OP_AND, 8'hF0, 8'h3C, 1'b0, 8'h30, 8'h00, 4'b0000, 2);
      run_op("or",       OP_OR,  8'hF0, 8'h3C, 1'b0, 8'hFC, 8'h00, 4'b0100, 2);
      run_op("xor",      OP_XOR, 8'hF0, 8'h3C, 1'b0, 8'hCC, 8'h00, 4'b0100, 2);
      run_op("add_wrap", OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 4'b1010, 2);

      // MUL with a stalled consumer and a stray request while busy
      issue(OP_MUL, 8'hFF, 8'hFF, 1'b0);
      lat = 1;
      wait_valid(lat);
      check("mulff_lat", 32'(lat), 32'(9));
      op = OP_ADD; a = 8'h11; b = 8'h22; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("mulff_hold_result", 32'(result),    32'(8'h01));
         check("mulff_hold_hi",     32'(hi),        32'(8'hFE));
         check("mulff_hold_flags",  32'(flags),     32'(4'b0010));
         check("mulff_hold_valid",  32'(out_valid), 32'(1));
         check("mulff_hold_ready",  32'(in_ready),  32'(0));
         step();
      end
      in_valid = 1'b0;
      handshake();

      // MUL frozen by ena for three cycles mid-execution
      issue(OP_MUL, 8'h0C, 8'h0D, 1'b0);
      lat = 1;
      step(); step(); lat += 2;
      ena = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         lat++;
         seen |= out_valid;
      end
      check("mulen_frozen_valid", 32'(seen), 32'(0));
      ena = 1'b1;
      wait_valid(lat);
      check("mulen_lat",    32'(lat),    32'(12));
      check("mulen_result", 32'(result), 32'(8'h9C));
      check("mulen_hi",     32'(hi),     32'(8'h00));
      check("mulen_flags",  32'(flags),  32'(4'b0100));
      handshake();

      // Reset pulse aborts an in-flight MUL
      issue(OP_MUL, 8'h03, 8'h05, 1'b0);
      step(); step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("abort_out_valid", 32'(out_valid), 32'(0));
      check("abort_result",    32'(result),    32'(0));
      check("abort_hi",        32'(hi),        32'(0));
      check("abort_flags",     32'(flags),     32'(0));
      check("abort_in_ready",  32'(in_ready),  32'(1));
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         seen |= out_valid;
      end
      check("abort_no_valid", 32'(seen), 32'(0));

      run_op("acc_rst", OP_ADD, 8'hAA, 8'h30, 1'b1, 8'h30, 8'h00, 4'b0000, 2);
      run_op("add_post", OP_ADD, 8'h10, 8'h20, 1'b0, 8'h30, 8'h00, 4'b0000, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
